// File: rtl/bit_place_accumulator_pkg.sv
// Shared types and constants for the bit-place shift-accumulate stage.
//   place_entry_t : one bit-place FIFO entry {skip, last, place}
//   state_t       : accumulator FSM states
//   PLACE_W       : width of the bit index field
//   WEIGHT_W      : width of the signed weight
package bit_place_accumulator_pkg;

  localparam int PLACE_W  = 3;
  localparam int WEIGHT_W = 8;

  typedef struct packed {
    logic               skip;   // activation was zero: no add, entry ends the activation
    logic               last;   // final entry of the current activation
    logic [PLACE_W-1:0] place;  // bit index of a set activation bit
  } place_entry_t;

  typedef enum logic [2:0] {
    S_W_WAIT = 3'd0,
    S_W_READ = 3'd1,
    S_P_WAIT = 3'd2,
    S_P_READ = 3'd3,
    S_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/bit_place_accumulator_fifo_pop_ctrl.sv
// fifo_pop_ctrl: wait-then-pulse-then-sample sequencer for one synchronous FIFO
// read port (rd_rdy = not empty, rd_en = one-cycle pop, data valid next cycle).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : owner is waiting for a word from this FIFO
//   rd_rdy      : FIFO not empty
//   rd_en       : one-cycle pop pulse to the FIFO
//   rd_data     : FIFO read data (valid the cycle after rd_en)
//   data_valid  : rd_data holds the popped word this cycle
//   data        : popped word
module fifo_pop_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         rd_rdy,
  output logic         rd_en,
  input  logic [W-1:0] rd_data,
  output logic         data_valid,
  output logic [W-1:0] data
);

  logic pulsed_q;

  // Pop only while the FIFO is non-empty, never on two consecutive cycles,
  // and never while reset is asserted (outputs must read 0 during reset).
  assign rd_en = rst_n && req && rd_rdy && !pulsed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulsed_q <= 1'b0;
    else        pulsed_q <= rd_en;
  end

  assign data_valid = pulsed_q;
  assign data       = rd_data;

endmodule

// File: rtl/bit_place_accumulator.sv
// bit_place_accumulator: bit-serial shift-accumulate stage. For each of VecLen
// activations it pops one signed weight, then pops bit-place entries until the
// activation's last (or skip) entry, adding sext(weight) <<< place for every
// non-skip entry. The finished dot product is offered on a valid/ready port.
// Ports:
//   CLK, RSTN                : clock, asynchronous active-low reset
//   PlaceFIFOReadReady/Enable/DataOut  : bit-place FIFO read port
//   WeightFIFOReadReady/Enable/DataOut : weight FIFO read port
//   ResultValid/Ready/Data   : dot product output
//   state_dbg                : current FSM state, for observation only
// Result handshake: ResultValid and ResultData are held stable from the cycle
// valid rises until a rising edge with ResultValid && ResultReady; that edge
// transfers the result. No FIFO is read while a result is pending.
// AccW must be at least 17 + clog2(VecLen) to hold the worst-case sum.
module bit_place_accumulator
  import bit_place_accumulator_pkg::*;
#(
  parameter int VecLen = 16,
  parameter int AccW   = 24
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   PlaceFIFOReadReady,
  output logic                   PlaceFIFOReadEnable,
  input  logic [PLACE_W+1:0]     PlaceFIFOReadDataOut,
  input  logic                   WeightFIFOReadReady,
  output logic                   WeightFIFOReadEnable,
  input  logic [WEIGHT_W-1:0]    WeightFIFOReadDataOut,
  output logic                   ResultValid,
  input  logic                   ResultReady,
  output logic [AccW-1:0]        ResultData,
  output state_t                 state_dbg
);

  localparam int CntW = (VecLen > 1) ? $clog2(VecLen) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(VecLen - 1);

  state_t               state;
  logic [CntW-1:0]      count;
  logic [AccW-1:0]      acc;
  logic [WEIGHT_W-1:0]  weight_q;
  logic                 result_valid_q;
  logic [AccW-1:0]      result_data_q;

  logic                 w_valid;
  logic [WEIGHT_W-1:0]  w_data;
  logic                 p_valid;
  logic [PLACE_W+1:0]   p_raw;
  place_entry_t         entry;

  logic [AccW-1:0]      weight_ext;
  logic [AccW-1:0]      addend;
  logic [AccW-1:0]      acc_sum;

  fifo_pop_ctrl #(.W(WEIGHT_W)) u_weight_pop (
    .clk        (CLK),
    .rst_n      (RSTN),
    .req        (state == S_W_WAIT),
    .rd_rdy     (WeightFIFOReadReady),
    .rd_en      (WeightFIFOReadEnable),
    .rd_data    (WeightFIFOReadDataOut),
    .data_valid (w_valid),
    .data       (w_data)
  );

  fifo_pop_ctrl #(.W(PLACE_W + 2)) u_place_pop (
    .clk        (CLK),
    .rst_n      (RSTN),
    .req        (state == S_P_WAIT),
    .rd_rdy     (PlaceFIFOReadReady),
    .rd_en      (PlaceFIFOReadEnable),
    .rd_data    (PlaceFIFOReadDataOut),
    .data_valid (p_valid),
    .data       (p_raw)
  );

  assign entry = place_entry_t'(p_raw);

  // Two's-complement shift-add; the sum wraps at AccW bits by construction.
  assign weight_ext = {{(AccW - WEIGHT_W){weight_q[WEIGHT_W-1]}}, weight_q};
  assign addend     = weight_ext << entry.place;
  assign acc_sum    = acc + addend;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state          <= S_W_WAIT;
      count          <= '0;
      acc            <= '0;
      weight_q       <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      case (state)
        S_W_WAIT: begin
          if (WeightFIFOReadEnable) state <= S_W_READ;
        end
        S_W_READ: begin
          // The pop issued in S_W_WAIT makes the word valid in this cycle.
          if (w_valid) weight_q <= w_data;
          state <= S_P_WAIT;
        end
        S_P_WAIT: begin
          if (PlaceFIFOReadEnable) state <= S_P_READ;
        end
        S_P_READ: begin
          if (p_valid && !entry.skip) acc <= acc_sum;
          if (!entry.last && !entry.skip) begin
            state <= S_P_WAIT;
          end else if (count == CntLast) begin
            state          <= S_OUT;
            result_valid_q <= 1'b1;
            result_data_q  <= entry.skip ? acc : acc_sum;
          end else begin
            count <= count + 1'b1;
            state <= S_W_WAIT;
          end
        end
        S_OUT: begin
          if (ResultReady) begin
            acc            <= '0;
            count          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            state          <= S_W_WAIT;
          end
        end
        default: state <= S_W_WAIT;
      endcase
    end
  end

  assign ResultValid = result_valid_q;
  assign ResultData  = result_data_q;
  assign state_dbg   = state;

endmodule
